rop3_operand_tx: RTL and testbench

- Transmit end of the ROP3 operand bus; drives the serial Bitmap/Mode interface consumed by the rop3 engines.
- Accepts whole operand frames {P, S, D, Mode} from an upstream producer through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each frame as P, S, D on consecutive cycles, with Mode held for the whole frame.
- Tracks outstanding frames against returning result-valid pulses and throttles new frames at a credit limit.

---
 rtl/rop3_pkg.sv | 16 +
 rtl/rop3_operand_tx_if.sv | 19 +
 rtl/rop3_frame_fifo.sv | 53 +++++
 rtl/rop3_operand_tx.sv | 174 +++++++++++++++++
 tb/tb_rop3_operand_tx.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rop3_pkg.sv
// Shared ROP3 operand-bus definitions: state encoding and default operand width.
// Operand order P, S, D matches the receiver's LOAD_P/LOAD_S/LOAD_D sequence.
package rop3_pkg;

  localparam int ROP3_STATE_W   = 3;
  localparam int ROP3_N_DEFAULT = 8;

  typedef enum logic [ROP3_STATE_W-1:0] {
    IDLE   = 3'd0,
    SEND_P = 3'd1,
    SEND_S = 3'd2,
    SEND_D = 3'd3,
    GAP    = 3'd4
  } tx_state_e;

endpackage

// File: rtl/rop3_operand_tx_if.sv
// Upstream frame handshake into the ROP3 operand transmitter.
// master = frame producer, slave = rop3_operand_tx.
interface rop3_operand_tx_if
  import rop3_pkg::*;
#(
  parameter int N = ROP3_N_DEFAULT
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_p;
  logic [N-1:0] in_s;
  logic [N-1:0] in_d;
  logic [7:0]   in_mode;

  modport master (output in_valid, in_p, in_s, in_d, in_mode, input in_ready);
  modport slave  (input in_valid, in_p, in_s, in_d, in_mode, output in_ready);

endinterface

// File: rtl/rop3_frame_fifo.sv
// Small synchronous FIFO holding whole operand frames; head is read combinationally.
// Occupancy counter is one bit wider than the pointers so full and empty are distinct.
module rop3_frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rop3_operand_tx.sv
// ROP3 operand transmitter: buffers {P,S,D,Mode} frames and serialises them with credit throttling.
// Define ROP3_TX_GAP_EN to insert one idle GAP cycle after every frame.
//
// state  | meaning
// IDLE   | bus idle, waiting for a buffered frame and a free credit
// SEND_P | P on bitmap, frame_start high
// SEND_S | S on bitmap
// SEND_D | D on bitmap; may chain straight into the next frame
// GAP    | one idle bus cycle between frames (ROP3_TX_GAP_EN only)
module rop3_operand_tx
  import rop3_pkg::*;
#(
  parameter int N          = ROP3_N_DEFAULT,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_OUT    = 4
) (
  input  logic                    clk,
  input  logic                    srst,
  rop3_operand_tx_if.slave        up,
  output logic [N-1:0]            bitmap,
  output logic [7:0]              mode,
  output logic                    frame_start,
  output logic                    busy,
  input  logic                    rsp_valid,
  output logic                    err_unexp
);

  localparam int FW = 3 * N + 8;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);

  tx_state_e      state_q;
  tx_state_e      state_d;
  logic [FW-1:0]  wr_data;
  logic [FW-1:0]  rd_data;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;
  logic           start;
  logic           credit_ok;
  logic           rsp_dec;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_d;
  logic [N-1:0]   head_p;
  logic [N-1:0]   head_s;
  logic [N-1:0]   head_d;
  logic [7:0]     head_mode;
  logic [N-1:0]   hold_s;
  logic [N-1:0]   hold_d;
  logic [7:0]     hold_mode;
  logic [N-1:0]   bitmap_d;
  logic [7:0]     mode_d;

  assign wr_data     = {up.in_mode, up.in_p, up.in_s, up.in_d};
  assign up.in_ready = !fifo_full;

  rop3_frame_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .srst    (srst),
    .push    (up.in_valid),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head_mode = rd_data[FW-1 -: 8];
  assign head_p    = rd_data[3*N-1 -: N];
  assign head_s    = rd_data[2*N-1 -: N];
  assign head_d    = rd_data[N-1:0];

  // A returning response frees its credit in the same cycle it can be reused.
  assign credit_ok = (cnt < MAX_OUT_C) || rsp_valid;
  assign start     = !fifo_empty && credit_ok;
  assign rsp_dec   = rsp_valid && (cnt != '0);
  assign busy      = !fifo_empty || (state_q != IDLE) || (cnt != '0);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND_P;
          pop     = 1'b1;
        end
      end
      SEND_P: state_d = SEND_S;
      SEND_S: state_d = SEND_D;
`ifdef ROP3_TX_GAP_EN
      SEND_D: state_d = GAP;
      GAP: begin
        if (start) begin
          state_d = SEND_P;
          pop     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
`else
      SEND_D: begin
        if (start) begin
          state_d = SEND_P;
          pop     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    bitmap_d = '0;
    mode_d   = '0;
    case (state_d)
      SEND_P: begin
        bitmap_d = head_p;
        mode_d   = head_mode;
      end
      SEND_S: begin
        bitmap_d = hold_s;
        mode_d   = hold_mode;
      end
      SEND_D: begin
        bitmap_d = hold_d;
        mode_d   = hold_mode;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt;
    case ({pop, rsp_dec})
      2'b10:   cnt_d = cnt + 1'b1;
      2'b01:   cnt_d = cnt - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= IDLE;
      bitmap      <= '0;
      mode        <= '0;
      frame_start <= 1'b0;
      cnt         <= '0;
      err_unexp   <= 1'b0;
      hold_s      <= '0;
      hold_d      <= '0;
      hold_mode   <= '0;
    end else begin
      state_q     <= state_d;
      bitmap      <= bitmap_d;
      mode        <= mode_d;
      frame_start <= (state_d == SEND_P);
      cnt         <= cnt_d;
      if (pop) begin
        hold_s    <= head_s;
        hold_d    <= head_d;
        hold_mode <= head_mode;
      end
      if (rsp_valid && (cnt == '0)) err_unexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rop3_operand_tx.sv
// Scoreboard bench for rop3_operand_tx: frames accepted upstream are queued and
// a negedge monitor checks the serial bus, credit throttling, in_ready, busy and err_unexp.
module tb_rop3_operand_tx;

  localparam int N          = 8;
  localparam int FIFO_DEPTH = 2;
  localparam int MAX_OUT    = 4;
`ifdef ROP3_TX_GAP_EN
  localparam int PERIOD   = 4;
  localparam bit GAP_MODE = 1'b1;
`else
  localparam int PERIOD   = 3;
  localparam bit GAP_MODE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         srst = 1'b1;
  logic         rsp_valid = 1'b0;
  logic [N-1:0] bitmap;
  logic [7:0]   mode;
  logic         frame_start;
  logic         busy;
  logic         err_unexp;

  rop3_operand_tx_if #(.N(N)) up ();

  rop3_operand_tx #(
    .N          (N),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_OUT    (MAX_OUT)
  ) dut (
    .clk         (clk),
    .srst        (srst),
    .up          (up),
    .bitmap      (bitmap),
    .mode        (mode),
    .frame_start (frame_start),
    .busy        (busy),
    .rsp_valid   (rsp_valid),
    .err_unexp   (err_unexp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] p;
    logic [N-1:0] s;
    logic [N-1:0] d;
    logic [7:0]   m;
    int           push_edge;
  } frame_t;

  frame_t exp_q[$];
  frame_t cur;
  int     fs_cyc_q[$];
  int     cyc = 0;
  int     tests = 0;
  int     fails = 0;
  int     ph = 0;
  int     out_model = 0;
  bit     err_exp = 1'b0;
  bit     prev_rsp = 1'b0;
  int     fs_count = 0;
  int     last_fs_cyc = -1;
  bit     saw_full = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Frames are recorded at the negedge before the edge that accepts them.
  always @(negedge clk) begin
    if (!srst && up.in_valid && up.in_ready)
      exp_q.push_back('{p: up.in_p, s: up.in_s, d: up.in_d, m: up.in_mode, push_edge: cyc + 1});
  end

  always @(negedge clk) begin
    if (srst) begin
      exp_q.delete();
      ph        = 0;
      out_model = 0;
      err_exp   = 1'b0;
      prev_rsp  = 1'b0;
    end else begin
      int occ;
      bit nonidle;
      bit should_start;
      bit dec;
      should_start = (ph == 0) && (exp_q.size() > 0) && (exp_q[0].push_edge < cyc)
                     && ((out_model < MAX_OUT) || prev_rsp);
      check("frame_start", frame_start, should_start);
      nonidle = 1'b1;
      case (ph)
        0: begin
          if (frame_start) begin
            fs_count++;
            last_fs_cyc = cyc;
            fs_cyc_q.push_back(cyc);
            if (exp_q.size() > 0) begin
              cur = exp_q.pop_front();
              check("bitmap_p", bitmap, cur.p);
              check("mode_p", mode, cur.m);
              ph = 1;
            end
          end else begin
            nonidle = 1'b0;
            check("idle_bitmap", bitmap, 0);
            check("idle_mode", mode, 0);
          end
        end
        1: begin
          check("bitmap_s", bitmap, cur.s);
          check("mode_s", mode, cur.m);
          ph = 2;
        end
        2: begin
          check("bitmap_d", bitmap, cur.d);
          check("mode_d", mode, cur.m);
          ph = GAP_MODE ? 3 : 0;
        end
        default: begin
          check("gap_bitmap", bitmap, 0);
          check("gap_mode", mode, 0);
          ph = 0;
        end
      endcase
      dec = prev_rsp && (out_model > 0);
      if (prev_rsp && out_model == 0) err_exp = 1'b1;
      out_model = out_model + (frame_start ? 1 : 0) - (dec ? 1 : 0);
      check("err_unexp", err_unexp, err_exp);
      occ = 0;
      foreach (exp_q[i]) if (exp_q[i].push_edge <= cyc) occ++;
      check("in_ready", up.in_ready, occ < FIFO_DEPTH);
      if (!up.in_ready) saw_full = 1'b1;
      check("busy", busy, nonidle || (occ > 0) || (out_model != 0));
      prev_rsp = rsp_valid;
    end
  end

  task automatic realign();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) realign();
  endtask

  task automatic push_frame(input logic [N-1:0] p, input logic [N-1:0] s,
                            input logic [N-1:0] d, input logic [7:0] m, output int acc_cyc);
    bit acc;
    int n;
    up.in_valid = 1'b1;
    up.in_p     = p;
    up.in_s     = s;
    up.in_d     = d;
    up.in_mode  = m;
    acc = 1'b0;
    n = 0;
    acc_cyc = -1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = up.in_ready;
      acc_cyc = cyc;
      realign();
      n++;
    end
    up.in_valid = 1'b0;
    check("push_accept", acc, 1);
  endtask

  task automatic push_rand(output int acc_cyc);
    push_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), acc_cyc);
  endtask

  task automatic pulse_rsp(output int a);
    a = cyc;
    rsp_valid = 1'b1;
    realign();
    rsp_valid = 1'b0;
  endtask

  task automatic wait_fs(input int target);
    int n = 0;
    while (fs_count < target && n < 200) begin
      settle();
      n++;
    end
    check("wait_frame_start", fs_count >= target, 1);
    realign();
  endtask

  task automatic drain();
    int n = 0;
    while ((out_model > 0 || exp_q.size() > 0 || ph != 0) && n < 400) begin
      rsp_valid = (out_model > int'(rsp_valid));
      realign();
      n++;
    end
    rsp_valid = 1'b0;
    wait_cycles(3);
    check("drain_done", n < 400, 1);
    settle();
    check("busy_after_drain", busy, 0);
    realign();
  endtask

  initial begin
    int acc, acc2, a, b, f0;
    up.in_valid = 1'b0;
    up.in_p     = '0;
    up.in_s     = '0;
    up.in_d     = '0;
    up.in_mode  = '0;

    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    settle();
    check("rst_bitmap", bitmap, 0);
    check("rst_mode", mode, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_err", err_unexp, 0);
    check("rst_in_ready", up.in_ready, 1);
    check("rst_busy", busy, 0);
    realign();

    // single frame with fixed operands
    f0 = fs_count;
    push_frame(8'hF0, 8'hCC, 8'hAA, 8'h96, acc);
    wait_fs(f0 + 1);
    check("single_latency", last_fs_cyc, acc + 2);
    wait_cycles(5);
    settle();
    check("single_idle_bitmap", bitmap, 0);
    check("single_busy_credit", busy, 1);
    realign();
    drain();

    // back-to-back frames, no responses
    saw_full = 1'b0;
    fs_cyc_q.delete();
    f0 = fs_count;
    repeat (3) push_rand(acc);
    wait_fs(f0 + 3);
    check("b2b_count", fs_cyc_q.size(), 3);
    if (fs_cyc_q.size() == 3) begin
      check("b2b_period_1", fs_cyc_q[1] - fs_cyc_q[0], PERIOD);
      check("b2b_period_2", fs_cyc_q[2] - fs_cyc_q[1], PERIOD);
    end
    check("b2b_saw_full", saw_full, 1);
    drain();

    // credit throttle at MAX_OUT
    f0 = fs_count;
    repeat (6) push_rand(acc);
    wait_cycles(12);
    settle();
    check("throttle_starts", fs_count - f0, MAX_OUT);
    check("throttle_busy", busy, 1);
    check("throttle_full", up.in_ready, 0);
    realign();
    pulse_rsp(a);
    settle();
    check("rsp_release_starts", fs_count - f0, MAX_OUT + 1);
    check("rsp_release_cycle", last_fs_cyc, a + 1);
    realign();
    wait_cycles(6);
    pulse_rsp(b);
    settle();
    check("simul_starts", fs_count - f0, MAX_OUT + 2);
    check("simul_cycle", last_fs_cyc, b + 1);
    realign();
    push_rand(acc);
    wait_cycles(10);
    settle();
    check("simul_cnt_held", fs_count - f0, MAX_OUT + 2);
    realign();
    drain();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      up.in_valid = ($urandom_range(0, 2) != 0);
      up.in_p     = 8'($urandom);
      up.in_s     = 8'($urandom);
      up.in_d     = 8'($urandom);
      up.in_mode  = 8'($urandom);
      rsp_valid   = (out_model > int'(rsp_valid)) && ($urandom_range(0, 1) == 0);
      realign();
    end
    up.in_valid = 1'b0;
    drain();

    // unexpected response
    pulse_rsp(a);
    settle();
    check("err_set", err_unexp, 1);
    realign();
    wait_cycles(5);
    settle();
    check("err_sticky", err_unexp, 1);
    realign();

    // reset clears sticky error, then reset mid-frame with one entry pending
    srst = 1'b1;
    realign();
    srst = 1'b0;
    settle();
    check("err_cleared", err_unexp, 0);
    realign();
    f0 = fs_count;
    push_frame(8'h11, 8'h22, 8'h33, 8'h44, acc);
    push_frame(8'h55, 8'h66, 8'h77, 8'h88, acc2);
    settle();
    check("pre_rst_starts", fs_count - f0, 1);
    check("pre_rst_bitmap_p", bitmap, 8'h11);
    @(posedge clk); #1;
    srst = 1'b1;
    realign();
    srst = 1'b0;
    settle();
    check("mid_rst_bitmap", bitmap, 0);
    check("mid_rst_mode", mode, 0);
    check("mid_rst_frame_start", frame_start, 0);
    check("mid_rst_in_ready", up.in_ready, 1);
    check("mid_rst_busy", busy, 0);
    realign();
    wait_cycles(10);
    settle();
    check("mid_rst_no_pending", fs_count - f0, 1);
    check("mid_rst_idle_bus", bitmap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
